vldrdy2to1_join: RTL and testbench
==================================

Name: vldrdy2to1_join

Overview:
- Buffered 2-to-1 valid/ready join. It is the counterpart to our lockstep 1-to-2 fork: it collects the two branch results and recombines them into one stream.
- Each input branch has its own small FIFO, so the two branches may return results with different latencies. The combined beat is issued only when both branches hold a beat.
- A registered output slice drives o_valid and o_data, so there is no combinational path from any input to the output.

Parameters:
- W1, 8: payload width of input branch 1.
- W2, 8: payload width of input branch 2.
- DEPTH, 2: entries per input FIFO. Must be a power of 2 and at least 2.
- CW, $clog2(DEPTH)+1: occupancy counter width. Derived; do not override.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid_1  in  1  branch 1 beat valid.
- i_ready_1  out  1  branch 1 FIFO can accept a beat.
- i_data_1  in  W1  branch 1 payload.
- i_valid_2  in  1  branch 2 beat valid.
- i_ready_2  out  1  branch 2 FIFO can accept a beat.
- i_data_2  in  W2  branch 2 payload.
- o_valid  out  1  joined beat valid (registered).
- o_ready  in  1  downstream accepts the joined beat.
- o_data  out  W1+W2  joined payload, {branch2, branch1}: branch 1 in the LSBs.
- o_cnt_1  out  CW  branch 1 FIFO occupancy (debug).
- o_cnt_2  out  CW  branch 2 FIFO occupancy (debug).

Behaviour:
- Reset values (asynchronous, while i_rst_n=0):
  - o_valid=0, o_data=0, o_cnt_1=0, o_cnt_2=0.
  - All read and write pointers = 0.
  - i_ready_1=1 and i_ready_2=1, because they derive from the counters.
  - Any beat presented while in reset is discarded.
- Transfer rule: a transfer happens on a port only when valid & ready are both 1 at the clock edge.
- Per-branch FIFO:
  - i_ready_n = (cnt_n < DEPTH). It depends only on registered state, never on i_valid or o_ready.
  - Write: i_valid_n & i_ready_n stores i_data_n at wptr_n; wptr_n increments and wraps modulo DEPTH.
  - Read: occurs on a join fire (see below); rptr_n increments and wraps modulo DEPTH.
  - Counter: cnt_n += write - read. A simultaneous write and read leaves cnt_n unchanged.
  - Full: i_ready_n=0 even if a read happens in the same cycle. There is no full-bypass; that cycle's beat is not taken.
  - Empty: there is no write-to-read fall-through. A beat written at edge N is readable from cycle N+1.
- Join fire condition: fire = (cnt_1!=0) & (cnt_2!=0) & (!o_valid | o_ready).
  - On fire: the head entries of both FIFOs pop together; o_data <= {head_2, head_1}; o_valid <= 1.
  - Else if o_valid & o_ready: o_valid <= 0.
  - Else: hold.
- Output stability: while o_valid=1 and o_ready=0, o_data and o_valid hold constant and no FIFO pops.
- o_valid never depends combinationally on o_ready.
- Latency: if both branches are accepted at edge N, o_valid=1 in cycle N+2. If the branches arrive at different edges, o_valid=1 two cycles after the later one.
- Throughput: one joined beat per cycle when both FIFOs are fed continuously and o_ready=1.
- Skew tolerance: one branch may run up to DEPTH beats ahead of the other. The leading branch then back-pressures via i_ready_n=0, while the trailing branch stays ready.
- Ordering: beats pair strictly in arrival order per branch, so the k-th beat of branch 1 joins with the k-th beat of branch 2.
- Reset mid-operation: all buffered and in-flight beats are lost and every output returns to its reset value immediately. Normal operation resumes at the first edge after release.
- Occupancy: o_cnt_n equals the internal cnt_n and never exceeds DEPTH.

Test Plan:
- Post-reset idle: release reset and drive no valids -> o_valid=0, i_ready_1=i_ready_2=1, o_cnt_1=o_cnt_2=0.
- Basic join (W1=W2=8, DEPTH=2, o_ready=1): send 0x11 on branch 1 and 0x22 on branch 2 at edge N -> o_valid=1 in cycle N+2 with o_data=0x2211, then o_valid=0 in cycle N+3.
- Skew and full: send 0xA0, 0xA1, 0xA2 on branch 1 with branch 2 idle -> 2 beats accepted, o_cnt_1=2, i_ready_1=0, 0xA2 held off. Then send 0xB0 on branch 2 -> o_data=0xB0A0, and 0xA2 is accepted the cycle after the pop.
- Back-pressure: o_ready=0 with 4 beat pairs offered -> o_valid=1 with o_data constant at the first pair, and both counts saturate at 2. Then raise o_ready -> the pairs emerge in order, one per cycle.
- Streaming: 16 pairs with random per-branch valid gaps and o_ready random at 50% -> the scoreboard sees an in-order pairwise match, no loss or duplication, and full throughput in gap-free windows.
- Reset mid-stream: assert i_rst_n=0 while o_valid=1 and both counts nonzero -> o_valid, o_data and counts go to 0 immediately. After release, a fresh pair 0x33/0x44 yields exactly 0x4433.

Source files
------------

// File: rtl/vldrdy2to1_join.sv
// Buffered 2-to-1 valid/ready join.
// Each branch lands in its own small FIFO so the two branches may return
// with different latencies. A joined beat is produced only when both FIFOs
// hold a head entry. The output is a registered slice, so nothing on the
// input side reaches o_valid/o_data combinationally.
module vldrdy2to1_join #(
  parameter int W1    = 8,
  parameter int W2    = 8,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid_1,
  output logic              i_ready_1,
  input  logic [W1-1:0]     i_data_1,
  input  logic              i_valid_2,
  output logic              i_ready_2,
  input  logic [W2-1:0]     i_data_2,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [W1+W2-1:0]  o_data,
  output logic [CW-1:0]     o_cnt_1,
  output logic [CW-1:0]     o_cnt_2
);

  localparam int AW = $clog2(DEPTH);

  logic [W1-1:0] mem_1 [DEPTH];
  logic [W2-1:0] mem_2 [DEPTH];
  logic [AW-1:0] wptr_1, rptr_1;
  logic [AW-1:0] wptr_2, rptr_2;
  logic [CW-1:0] cnt_1, cnt_2;
  logic          wr_1, wr_2;
  logic          fire;

  // Readiness comes only from the registered counters: a full FIFO refuses a
  // beat even if the join pops it in the same cycle.
  assign i_ready_1 = (cnt_1 < CW'(DEPTH));
  assign i_ready_2 = (cnt_2 < CW'(DEPTH));
  assign wr_1      = i_valid_1 & i_ready_1;
  assign wr_2      = i_valid_2 & i_ready_2;

  // Pop both heads together when both hold data and the output slice is free
  // or being drained this cycle.
  assign fire = (cnt_1 != '0) & (cnt_2 != '0) & (~o_valid | o_ready);

  assign o_cnt_1 = cnt_1;
  assign o_cnt_2 = cnt_2;

  // Branch 1 storage; contents are only observed after a write, so no reset.
  always_ff @(posedge i_clk) begin
    if (wr_1) mem_1[wptr_1] <= i_data_1;
  end

  // Branch 2 storage.
  always_ff @(posedge i_clk) begin
    if (wr_2) mem_2[wptr_2] <= i_data_2;
  end

  // Branch 1 pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_1 <= '0;
      rptr_1 <= '0;
      cnt_1  <= '0;
    end else begin
      if (wr_1) wptr_1 <= wptr_1 + 1'b1;
      if (fire) rptr_1 <= rptr_1 + 1'b1;
      if (wr_1 && !fire)      cnt_1 <= cnt_1 + 1'b1;
      else if (!wr_1 && fire) cnt_1 <= cnt_1 - 1'b1;
    end
  end

  // Branch 2 pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_2 <= '0;
      rptr_2 <= '0;
      cnt_2  <= '0;
    end else begin
      if (wr_2) wptr_2 <= wptr_2 + 1'b1;
      if (fire) rptr_2 <= rptr_2 + 1'b1;
      if (wr_2 && !fire)      cnt_2 <= cnt_2 + 1'b1;
      else if (!wr_2 && fire) cnt_2 <= cnt_2 - 1'b1;
    end
  end

  // Registered output slice: load on fire, drop valid once consumed, else hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (fire) begin
      o_valid <= 1'b1;
      o_data  <= {mem_2[rptr_2], mem_1[rptr_1]};
    end else if (o_valid && o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vldrdy2to1_join.sv
// Directed bench for vldrdy2to1_join (W1=W2=8, DEPTH=2).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_vldrdy2to1_join;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid_1, i_ready_1;
  logic [7:0]  i_data_1;
  logic        i_valid_2, i_ready_2;
  logic [7:0]  i_data_2;
  logic        o_valid, o_ready;
  logic [15:0] o_data;
  logic [1:0]  o_cnt_1, o_cnt_2;

  int n_cmp = 0;
  int n_mis = 0;

  int          k, k1, k2, rx, cyc;
  logic        acc, a1, a2, hs;
  logic [15:0] got, e;

  vldrdy2to1_join #(.W1(8), .W2(8), .DEPTH(2)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid_1 (i_valid_1),
    .i_ready_1 (i_ready_1),
    .i_data_1  (i_data_1),
    .i_valid_2 (i_valid_2),
    .i_ready_2 (i_ready_2),
    .i_data_2  (i_data_2),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_cnt_1   (o_cnt_1),
    .o_cnt_2   (o_cnt_2)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // Reset, with a beat offered during reset that must be discarded.
    i_rst_n = 1'b0; o_ready = 1'b0;
    i_valid_1 = 1'b1; i_data_1 = 8'h55;
    i_valid_2 = 1'b1; i_data_2 = 8'h66;
    tick(); tick();
    check("rst_o_valid", 32'(o_valid), 0);
    check("rst_o_data",  32'(o_data), 0);
    check("rst_cnt_1",   32'(o_cnt_1), 0);
    check("rst_ready_1", 32'(i_ready_1), 1);
    i_rst_n = 1'b1; i_valid_1 = 1'b0; i_valid_2 = 1'b0;
    tick();
    check("idle_o_valid", 32'(o_valid), 0);
    check("idle_ready_1", 32'(i_ready_1), 1);
    check("idle_ready_2", 32'(i_ready_2), 1);
    check("idle_cnt_1",   32'(o_cnt_1), 0);
    check("idle_cnt_2",   32'(o_cnt_2), 0);

    // Basic join.
    o_ready = 1'b1;
    i_valid_1 = 1'b1; i_data_1 = 8'h11;
    i_valid_2 = 1'b1; i_data_2 = 8'h22;
    tick();
    i_valid_1 = 1'b0; i_valid_2 = 1'b0;
    check("basic_cnt_1", 32'(o_cnt_1), 1);
    check("basic_cnt_2", 32'(o_cnt_2), 1);
    check("basic_early_valid", 32'(o_valid), 0);
    tick();
    check("basic_valid", 32'(o_valid), 1);
    check("basic_data",  32'(o_data), 32'h2211);
    check("basic_cnt_drained", 32'(o_cnt_1), 0);
    tick();
    check("basic_valid_drop", 32'(o_valid), 0);

    // Skew and full: branch 1 runs ahead.
    i_valid_1 = 1'b1; i_data_1 = 8'hA0;
    tick();
    i_data_1 = 8'hA1;
    tick();
    check("skew_cnt_1_full", 32'(o_cnt_1), 2);
    check("skew_ready_1_low", 32'(i_ready_1), 0);
    i_data_1 = 8'hA2;
    tick();
    check("skew_a2_held", 32'(o_cnt_1), 2);
    check("skew_ready_2_high", 32'(i_ready_2), 1);
    check("skew_no_valid", 32'(o_valid), 0);
    i_valid_2 = 1'b1; i_data_2 = 8'hB0;
    tick();
    i_valid_2 = 1'b0;
    check("skew_cnt_1_still", 32'(o_cnt_1), 2);
    check("skew_cnt_2", 32'(o_cnt_2), 1);
    tick();
    check("skew_join_valid", 32'(o_valid), 1);
    check("skew_join_data", 32'(o_data), 32'hB0A0);
    check("skew_pop_cnt_1", 32'(o_cnt_1), 1);
    check("skew_ready_1_back", 32'(i_ready_1), 1);
    tick();
    i_valid_1 = 1'b0;
    check("skew_a2_taken", 32'(o_cnt_1), 2);
    check("skew_valid_idle", 32'(o_valid), 0);
    i_valid_2 = 1'b1; i_data_2 = 8'hB1;
    tick();
    i_data_2 = 8'hB2;
    tick();
    i_valid_2 = 1'b0;
    check("skew_pair1", 32'(o_data), 32'hB1A1);
    check("skew_pair1_cnt_2", 32'(o_cnt_2), 1);
    tick();
    check("skew_pair2", 32'(o_data), 32'hB2A2);
    check("skew_pair2_valid", 32'(o_valid), 1);
    tick();
    check("skew_end_valid", 32'(o_valid), 0);
    check("skew_end_cnt_1", 32'(o_cnt_1), 0);

    // Back-pressure: four pairs offered with o_ready low.
    o_ready = 1'b0; k = 0;
    for (int t = 0; t < 5; t++) begin
      i_valid_1 = (k < 4); i_valid_2 = (k < 4);
      i_data_1 = 8'hC0 + 8'(k); i_data_2 = 8'hD0 + 8'(k);
      acc = i_valid_1 & i_ready_1 & i_ready_2;
      tick();
      if (acc) k++;
      if (t >= 2) check("bp_data_hold", 32'(o_data), 32'hD0C0);
    end
    check("bp_accepted", 32'(k), 3);
    check("bp_valid", 32'(o_valid), 1);
    check("bp_cnt_1", 32'(o_cnt_1), 2);
    check("bp_cnt_2", 32'(o_cnt_2), 2);
    check("bp_ready_1", 32'(i_ready_1), 0);
    o_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      i_valid_1 = (k < 4); i_valid_2 = (k < 4);
      i_data_1 = 8'hC0 + 8'(k); i_data_2 = 8'hD0 + 8'(k);
      acc = i_valid_1 & i_ready_1 & i_ready_2;
      tick();
      if (acc) k++;
      e = {8'hD0 + 8'(j), 8'hC0 + 8'(j)};
      check("bp_drain_valid", 32'(o_valid), 1);
      check("bp_drain_data", 32'(o_data), 32'(e));
    end
    i_valid_1 = 1'b0; i_valid_2 = 1'b0;
    tick();
    check("bp_end_valid", 32'(o_valid), 0);

    // Gap-free streaming: eight pairs, eight consecutive output beats.
    o_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      i_valid_1 = (t < 8); i_valid_2 = (t < 8);
      i_data_1 = 8'h40 + 8'(t); i_data_2 = 8'h80 + 8'(t);
      tick();
      check("tput_valid", 32'(o_valid), (t >= 1 && t <= 8) ? 1 : 0);
      if (t >= 1 && t <= 8) begin
        e = {8'h80 + 8'(t - 1), 8'h40 + 8'(t - 1)};
        check("tput_data", 32'(o_data), 32'(e));
      end
    end

    // Random gaps and random o_ready, scoreboarded by pair index.
    k1 = 0; k2 = 0; rx = 0; cyc = 0;
    while (rx < 16 && cyc < 500) begin
      i_valid_1 = (k1 < 16) && ($urandom_range(0, 2) != 0);
      i_valid_2 = (k2 < 16) && ($urandom_range(0, 2) != 0);
      i_data_1 = 8'h60 + 8'(k1);
      i_data_2 = 8'hA0 + 8'(k2);
      o_ready = 1'($urandom_range(0, 1));
      a1 = i_valid_1 & i_ready_1;
      a2 = i_valid_2 & i_ready_2;
      hs = o_valid & o_ready;
      got = o_data;
      tick();
      if (a1) k1++;
      if (a2) k2++;
      if (hs) begin
        e = {8'hA0 + 8'(rx), 8'h60 + 8'(rx)};
        check("stream_data", 32'(got), 32'(e));
        rx++;
      end
      cyc++;
    end
    check("stream_count", 32'(rx), 16);
    i_valid_1 = 1'b0; i_valid_2 = 1'b0; o_ready = 1'b1;
    tick(); tick();
    check("stream_no_dup_valid", 32'(o_valid), 0);
    check("stream_cnt_1", 32'(o_cnt_1), 0);
    check("stream_cnt_2", 32'(o_cnt_2), 0);

    // Reset mid-stream.
    o_ready = 1'b0; k = 0;
    for (int t = 0; t < 3; t++) begin
      i_valid_1 = 1'b1; i_valid_2 = 1'b1;
      i_data_1 = 8'hE0 + 8'(k); i_data_2 = 8'hF0 + 8'(k);
      acc = i_ready_1 & i_ready_2;
      tick();
      if (acc) k++;
    end
    check("mid_pre_valid", 32'(o_valid), 1);
    check("mid_pre_cnt_1", 32'(o_cnt_1), 2);
    check("mid_pre_cnt_2", 32'(o_cnt_2), 2);
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 0);
    check("mid_rst_data", 32'(o_data), 0);
    check("mid_rst_cnt_1", 32'(o_cnt_1), 0);
    check("mid_rst_cnt_2", 32'(o_cnt_2), 0);
    check("mid_rst_ready_2", 32'(i_ready_2), 1);
    tick(); tick();
    i_rst_n = 1'b1; i_valid_1 = 1'b0; i_valid_2 = 1'b0; o_ready = 1'b1;
    tick();
    i_valid_1 = 1'b1; i_data_1 = 8'h33;
    i_valid_2 = 1'b1; i_data_2 = 8'h44;
    tick();
    i_valid_1 = 1'b0; i_valid_2 = 1'b0;
    tick();
    check("post_rst_valid", 32'(o_valid), 1);
    check("post_rst_data", 32'(o_data), 32'h4433);
    tick();
    check("post_rst_drop", 32'(o_valid), 0);
    check("post_rst_cnt_1", 32'(o_cnt_1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
